// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: default operand width, controller
// state encoding and adder mode constants.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P_REQ  = 3'd1,
    ST_P_WAIT = 3'd2,
    ST_C_REQ  = 3'd3,
    ST_C_WAIT = 3'd4,
    ST_FIN    = 3'd5
  } modadd_state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/modadd_ctrl.sv
// Modular add/sub controller: issues a primary add/sub and an unconditional
// +/-M correction to the shared adder, then selects the reduced result.
module modadd_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH:0]   add_a,
  output logic [WIDTH:0]   add_b,
  input  logic [WIDTH+1:0] add_result,
  input  logic             add_done
);

  modadd_state_e    state, state_nxt;
  logic             first_wait;
  logic             sub_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH+1:0] t_q;
  logic             accept;
  logic             prim_done;
  logic             corr_done;

  // Picks the reduced value: for add, t-M wins unless it went negative;
  // for sub, t+M is only needed when a-b went negative.
  function automatic logic [WIDTH-1:0] fin_select(input logic             sub,
                                                  input logic [WIDTH+1:0] t,
                                                  input logic [WIDTH+1:0] u);
    if (sub == MODE_SUB)
      return t[WIDTH+1] ? u[WIDTH-1:0] : t[WIDTH-1:0];
    return u[WIDTH+1] ? t[WIDTH-1:0] : u[WIDTH-1:0];
  endfunction

  assign accept    = (state == ST_IDLE) && start;
  // The adder may still show the previous done level in the first wait cycle.
  assign prim_done = (state == ST_P_WAIT) && !first_wait && add_done;
  assign corr_done = (state == ST_C_WAIT) && !first_wait && add_done;

  assign done      = (state == ST_FIN);
  assign busy      = (state != ST_IDLE);
  assign add_start = (state == ST_P_REQ) || (state == ST_C_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_wait <= add_start;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_P_REQ;
      ST_P_REQ:  state_nxt = ST_P_WAIT;
      ST_P_WAIT: if (prim_done) state_nxt = ST_C_REQ;
      ST_C_REQ:  state_nxt = ST_C_WAIT;
      ST_C_WAIT: if (corr_done) state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Adder request operands and result: visible outputs, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_subtract <= MODE_ADD;
      add_a        <= '0;
      add_b        <= '0;
      result       <= '0;
    end else begin
      if (accept) begin
        add_subtract <= op_sub;
        add_a        <= {1'b0, in_a};
        add_b        <= {1'b0, in_b};
      end else if (prim_done) begin
        add_subtract <= (sub_q == MODE_SUB) ? MODE_ADD : MODE_SUB;
        add_a        <= add_result[WIDTH:0];
        add_b        <= {1'b0, m_q};
      end
      if (corr_done)
        result <= fin_select(sub_q, t_q, add_result);
    end
  end

  // Operation context: only meaningful while busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_q   <= in_m;
      sub_q <= op_sub;
    end
    if (prim_done)
      t_q <= add_result;
  end

endmodule

// File: tb/tb_modadd_ctrl.sv
// Bench for modadd_ctrl with a behavioural multi-precision adder and a
// plain-arithmetic modular reference model.
module tb_modadd_ctrl;

  localparam int W  = 512;
  localparam int XW = W + 2;

  logic           clk;
  logic           reset;
  logic           start;
  logic           op_sub;
  logic [W-1:0]   in_a, in_b, in_m;
  logic [W-1:0]   result;
  logic           done, busy;
  logic           add_start, add_subtract;
  logic [W:0]     add_a, add_b;
  logic [W+1:0]   add_result;
  logic           add_done;

  int n_chk  = 0;
  int n_pass = 0;

  modadd_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Behavioural adder: first add_start of an op uses lat_p, second lat_c.
  int         lat_p = 2;
  int         lat_c = 2;
  int         adder_cnt;
  int         nstart_add;
  bit         adder_pend;
  logic [W:0] cap_a, cap_b;
  logic       cap_sub;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      add_done   <= 1'b0;
      add_result <= '0;
      adder_pend <= 1'b0;
      adder_cnt  <= 0;
      nstart_add <= 0;
    end else if (add_start) begin
      cap_a      <= add_a;
      cap_b      <= add_b;
      cap_sub    <= add_subtract;
      add_done   <= 1'b0;
      adder_pend <= 1'b1;
      adder_cnt  <= (((nstart_add % 2) == 1) ? lat_c : lat_p) - 1;
      nstart_add <= nstart_add + 1;
    end else if (adder_pend) begin
      if (adder_cnt <= 1) begin
        add_done   <= 1'b1;
        add_result <= cap_sub ? ({1'b0, cap_a} - {1'b0, cap_b}) : ({1'b0, cap_a} + {1'b0, cap_b});
        adder_pend <= 1'b0;
      end else begin
        adder_cnt <= adder_cnt - 1;
      end
    end
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m, input logic sub);
    logic [XW-1:0] aa, bb, mm;
    aa = {2'b00, a};
    bb = {2'b00, b};
    mm = {2'b00, m};
    if (sub) return W'((aa + mm - bb) % mm);
    return W'((aa + bb) % mm);
  endfunction

  // Scoreboard: tracks accepted requests and checks every output cycle.
  bit           active;
  bit           prev_done;
  int           starts_seen;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", XW'(busy), XW'(active));
      if (active && add_start) starts_seen++;
      if (adder_pend) begin
        check("add_a_stable", XW'(add_a), XW'(cap_a));
        check("add_b_stable", XW'(add_b), XW'(cap_b));
        check("add_mode_stable", XW'(add_subtract), XW'(cap_sub));
      end
      if (done) begin
        check("done_single", XW'(prev_done), XW'(0));
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done=1 required no pending request");
        end else begin
          check("result_model", XW'(result), XW'(exp_q.pop_front()));
        end
        check("add_start_count", XW'(starts_seen), XW'(2));
        starts_seen = 0;
      end
      if (start && !active) begin
        exp_q.push_back(model(in_a, in_b, in_m, op_sub));
        active = 1'b1;
      end
      if (done) active = 1'b0;
      prev_done = done;
    end else begin
      active      = 1'b0;
      prev_done   = 1'b0;
      starts_seen = 0;
      exp_q.delete();
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_timeout: got no done required done within 200 cycles", name);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                       input logic sub);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_m = m; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_a = ~a; in_b = ~b; in_m = '0; op_sub = ~sub;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic sub, input int lp, input int lc,
                        input logic [W-1:0] exp, input bit post, input string name);
    lat_p = lp;
    lat_c = lc;
    issue(a, b, m, sub);
    wait_done(name);
    check(name, XW'(result), XW'(exp));
    if (post) begin
      @(negedge clk);
      check({name, "_done_low"}, XW'(done), XW'(0));
      check({name, "_busy_low"}, XW'(busy), XW'(0));
      check({name, "_result_held"}, XW'(result), XW'(exp));
    end
  endtask

  logic [W-1:0] big_m, big_ab, big_exp;
  int           seen_starts;

  initial begin
    reset = 1'b1; start = 1'b0; op_sub = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", XW'(result), XW'(0));
    check("rst_done", XW'(done), XW'(0));
    check("rst_busy", XW'(busy), XW'(0));
    check("rst_add_start", XW'(add_start), XW'(0));
    check("rst_add_sub", XW'(add_subtract), XW'(0));
    check("rst_add_a", XW'(add_a), XW'(0));
    check("rst_add_b", XW'(add_b), XW'(0));
    reset = 1'b0;

    run_op(5, 7, 13, 1'b0, 2, 2, 12, 1'b1, "add_5_7");
    run_op(9, 8, 13, 1'b0, 3, 2, 4, 1'b0, "add_9_8");
    run_op(6, 7, 13, 1'b0, 2, 5, 0, 1'b0, "add_6_7");
    run_op(3, 5, 13, 1'b1, 4, 3, 11, 1'b1, "sub_3_5");
    run_op(5, 5, 13, 1'b1, 2, 2, 0, 1'b0, "sub_5_5");
    run_op(12, 0, 13, 1'b1, 3, 4, 12, 1'b1, "sub_12_0");

    big_m   = '1;
    big_ab  = big_m - 1;
    big_exp = {{509{1'b1}}, 3'b101};
    run_op(big_ab, big_ab, big_m, 1'b0, 2, 3, big_exp, 1'b1, "add_big");

    // Second start while the primary op is in flight must be dropped.
    lat_p = 4; lat_c = 3;
    issue(2, 3, 13, 1'b0);
    @(posedge clk); #1;
    in_a = 10; in_b = 11; in_m = 13; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start");
    check("ignored_start", XW'(result), XW'(5));

    // Start pulsed only during the done cycle must not begin an op.
    #1;
    in_a = 1; in_b = 1; in_m = 13; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("fin_start_busy", XW'(busy), XW'(0));
    end
    check("fin_start_result", XW'(result), XW'(5));

    // Reset during the correction wait aborts everything.
    lat_p = 2; lat_c = 8;
    issue(4, 4, 13, 1'b0);
    seen_starts = 1;
    for (int i = 0; i < 50 && seen_starts < 2; i++) begin
      @(negedge clk);
      if (add_start) seen_starts++;
    end
    check("reset_reached_creq", XW'(seen_starts), XW'(2));
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_result", XW'(result), XW'(0));
    check("abort_done", XW'(done), XW'(0));
    check("abort_busy", XW'(busy), XW'(0));
    check("abort_add_start", XW'(add_start), XW'(0));
    check("abort_add_sub", XW'(add_subtract), XW'(0));
    check("abort_add_a", XW'(add_a), XW'(0));
    check("abort_add_b", XW'(add_b), XW'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(7, 9, 13, 1'b1, 3, 2, 11, 1'b1, "after_reset_sub");
    run_op(12, 12, 13, 1'b0, 2, 2, 11, 1'b1, "after_reset_add");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000");
    $fatal(1);
  end

endmodule
